// File: rtl/inst_fetch_if.sv
// Instruction-memory read port: req/gnt request phase, in-order rvalid response phase.
// The fetch stage drives the master side, the memory (or its model) drives the slave side.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: issues sequential word reads, buffers returned instructions with their PC,
// and presents the FIFO head to decode; redirect flushes and drops in-flight responses.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    inst_fetch_if.master        imem,
    input  logic                incr_pc_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic [31:0]         d_inst_o,
    output logic [31:0]         d_pc_o,
    output logic                d_valid_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]        last_pc_q;
    logic [31:0]        inst_mem_q [FIFO_DEPTH];
    logic [31:0]        pc_mem_q   [FIFO_DEPTH];

    logic               req;
    logic               push;
    logic               pop;
    logic               rsp_any;
    logic [CNT_W-1:0]   inflight;
    logic [OCC_W-1:0]   occupancy;
    logic [31:0]        push_pc;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        req           = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        inflight      = outstanding_q + discard_q;
        rsp_any       = imem.imem_rvalid && (inflight != '0);
        occupancy     = OCC_W'(count_q) + OCC_W'(outstanding_q);
        // Responses return in order, so the oldest in-flight request sits 4*outstanding behind.
        push_pc       = fetch_pc_q - 32'({outstanding_q, 2'b00});

        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                req  = (occupancy < OCC_W'(FIFO_DEPTH));
                push = imem.imem_rvalid && (outstanding_q != '0);
                if (req && imem.imem_gnt) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
                outstanding_d = outstanding_q + CNT_W'(req && imem.imem_gnt) - CNT_W'(push);
            end
            DRAIN: begin
                if (rsp_any) begin
                    discard_d = discard_q - 1'b1;
                end
                if (discard_d == '0) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        pop      = incr_pc_i && (count_q != '0);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        // Request is withdrawn combinationally, so no handshake can complete in a redirect cycle.
        if (redirect_i) begin
            req           = 1'b0;
            push          = 1'b0;
            pop           = 1'b0;
            fetch_pc_d    = {redirect_pc_i[31:2], 2'b00};
            discard_d     = inflight - CNT_W'(rsp_any);
            outstanding_d = '0;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            state_d       = (discard_d != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            last_pc_q     <= d_pc_o;
        end
    end

    // Buffer storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= push_pc;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc_q;
    assign d_valid_o      = (count_q != '0);
    assign d_inst_o       = d_valid_o ? inst_mem_q[rd_ptr_q] : NOP;
    assign d_pc_o         = d_valid_o ? pc_mem_q[rd_ptr_q] : last_pc_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: in-order memory model with random grant/latency, and a queue-based
// model of what decode must see (sequential PCs per redirect, memory contents per PC).
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk_i         = 1'b0;
    logic        rst_n_i       = 1'b1;
    logic        incr_pc_i     = 1'b0;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] d_inst_o;
    logic [31:0] d_pc_o;
    logic        d_valid_o;

    inst_fetch_if imem ();

    inst_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .imem         (imem),
        .incr_pc_i    (incr_pc_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .d_inst_o     (d_inst_o),
        .d_pc_o       (d_pc_o),
        .d_valid_o    (d_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          since_rst = 0;
    int          stale_cnt = 0;
    int          lat_lo    = 1;
    int          lat_hi    = 1;
    int          rv_prob   = 100;
    logic        stale_rv  = 1'b0;
    logic [31:0] exp_req_pc = RESET_PC;
    logic [31:0] hold_pc    = '0;
    mreq_t       mq[$];      // granted requests not yet answered by memory
    logic [31:0] fifo_q[$];  // PCs decode should currently see, head first

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n_i            = 1'b0;
        imem.imem_gnt      = 1'b0;
        imem.imem_rvalid   = 1'b0;
        imem.imem_rdata    = '0;
        incr_pc_i          = 1'b0;
        redirect_i         = 1'b0;
        #1;
        check("rst_req", 32'(imem.imem_req), 32'd0);
        check("rst_valid", 32'(d_valid_o), 32'd0);
        mq.delete();
        fifo_q.delete();
        stale_cnt  = 0;
        exp_req_pc = RESET_PC;
        hold_pc    = '0;
        since_rst  = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_addr", imem.imem_addr, RESET_PC);
        check("rst_inst", d_inst_o, NOP);
        check("rst_pc", d_pc_o, 32'd0);
        rst_n_i = 1'b1;
        $display("reset applied and released at cycle %0d", cyc);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step(input logic g, input logic inc, input logic rd, input logic [31:0] rpc);
        logic        rv;
        logic        exp_req;
        logic        pop_ok;
        logic [31:0] rdat;
        rv   = 1'b0;
        rdat = $urandom;
        if (stale_rv) begin
            rv = 1'b1;
        end else if (mq.size() > 0 && mq[0].due <= cyc && int'($urandom_range(99)) < rv_prob) begin
            rv   = 1'b1;
            rdat = mem_word(mq[0].addr);
        end
        imem.imem_gnt    = g;
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rdat;
        incr_pc_i        = inc;
        redirect_i       = rd;
        redirect_pc_i    = rpc;
        exp_req = !rd && since_rst > 0 && stale_cnt == 0 && (fifo_q.size() + mq.size() < DEPTH);

        @(negedge clk_i);
        check("req", 32'(imem.imem_req), 32'(exp_req));
        check("addr", imem.imem_addr, exp_req_pc);
        check("d_valid", 32'(d_valid_o), 32'(fifo_q.size() > 0));
        if (fifo_q.size() > 0) begin
            check("d_pc", d_pc_o, fifo_q[0]);
            check("d_inst", d_inst_o, mem_word(fifo_q[0]));
            hold_pc = fifo_q[0];
        end else begin
            check("d_nop", d_inst_o, NOP);
            check("d_pc_hold", d_pc_o, hold_pc);
        end
        $display("cyc %0d gnt=%0b rv=%0b inc=%0b rd=%0b req=%0b addr=%08h valid=%0b pc=%08h inst=%08h",
                 cyc, g, rv, inc, rd, imem.imem_req, imem.imem_addr, d_valid_o, d_pc_o, d_inst_o);

        @(posedge clk_i);
        pop_ok = inc && (fifo_q.size() > 0);
        if (rv && !stale_rv) begin
            if (stale_cnt > 0) stale_cnt--;
            else fifo_q.push_back(mq[0].addr);
            void'(mq.pop_front());
        end
        if (pop_ok) void'(fifo_q.pop_front());
        if (exp_req && g) begin
            mq.push_back('{exp_req_pc, cyc + int'($urandom_range(lat_hi, lat_lo))});
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (rd) begin
            fifo_q.delete();
            stale_cnt  = mq.size();
            exp_req_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
        since_rst++;
        #1;
    endtask

    initial begin
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        #2;
        do_reset();

        // Streaming: one instruction per cycle after the initial latency.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        // Decode stalled: FIFO fills, requests stop at the depth limit.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Grant withheld: request and address must hold.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect with two requests in flight: both responses dropped before refetch.
        rv_prob = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        rv_prob = 100;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Address wrap at the top of the 32-bit space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Reset with requests in flight, then a stale response in the first cycle.
        rv_prob = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        do_reset();
        stale_rv = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        stale_rv = 1'b0;
        rv_prob  = 100;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Random traffic: grant, latency, response gaps, stalls and redirects.
        lat_lo  = 1;
        lat_hi  = 4;
        rv_prob = 70;
        for (int i = 0; i < 3000; i++) begin
            logic        r_rd;
            logic [31:0] r_pc;
            r_rd = (int'($urandom_range(99)) < 3);
            r_pc = ($urandom_range(1) == 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
            step(int'($urandom_range(99)) < 70, int'($urandom_range(99)) < 60, r_rd, r_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
